// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared definitions for the CPU I/O bridge.
//   DEF_IN_DEPTH / DEF_OUT_DEPTH : default FIFO depths in bytes
//   DEF_INT_PULSE                : default interrupt high time in cycles
//   int_state_t                  : interrupt FSM state encoding
package io_bridge_pkg;

  localparam int unsigned DEF_IN_DEPTH  = 4;
  localparam int unsigned DEF_OUT_DEPTH = 4;
  localparam int unsigned DEF_INT_PULSE = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } int_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: single-clock FIFO with registered storage and occupancy count.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, din     : write request and data; accepted when not full, or when
//                   full and a pop happens on the same edge
//   pop, dout     : read request and head byte; dout is '0 while empty
//   full, empty   : occupancy flags derived from the registered count
//   count         : occupancy 0..DEPTH
module io_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

  // When full, a simultaneous pop frees the slot being written, so the
  // write may proceed; reset suppresses any transfer in its cycle.
  assign do_push = push & (~full | pop) & ~rst;
  assign do_pop  = pop & ~empty & ~rst;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_bridge.sv
// io_bridge: byte bridge between a simple CPU I/O port and two external
// valid/ready streams, with an interrupt request for incoming data.
//   clk, rst                       : clock, synchronous active-high reset
//   i_port, in_ack                 : input FIFO head to CPU, CPU pop strobe
//   int_sig, int_en                : interrupt request, interrupt enable
//   o_port, o_wr                   : CPU write byte and write strobe
//   ext_in_valid/ready/data        : external source into the input FIFO
//   ext_out_valid/ready/data       : output FIFO towards the external sink
//   in_count                       : input FIFO occupancy
//   ovf                            : sticky, a CPU write was dropped on full
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int unsigned IN_DEPTH  = DEF_IN_DEPTH,
  parameter int unsigned OUT_DEPTH = DEF_OUT_DEPTH,
  parameter int unsigned INT_PULSE = DEF_INT_PULSE
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [7:0]                  i_port,
  input  logic                        in_ack,
  output logic                        int_sig,
  input  logic                        int_en,
  input  logic [7:0]                  o_port,
  input  logic                        o_wr,
  input  logic                        ext_in_valid,
  output logic                        ext_in_ready,
  input  logic [7:0]                  ext_in_data,
  output logic                        ext_out_valid,
  input  logic                        ext_out_ready,
  output logic [7:0]                  ext_out_data,
  output logic [$clog2(IN_DEPTH):0]   in_count,
  output logic                        ovf
);

  localparam logic [3:0] PULSE_LOAD = 4'(INT_PULSE - 1);

  logic                        in_full;
  logic                        in_empty;
  logic                        in_push;
  logic                        in_pop;
  logic                        out_full;
  logic                        out_empty;
  logic                        out_pop;
  logic [$clog2(OUT_DEPTH):0]  unused_out_count;

  int_state_t state;
  logic [3:0] pulse_cnt;

  assign ext_in_ready  = ~in_full;
  assign in_push       = ext_in_valid & ext_in_ready;
  assign in_pop        = in_ack & ~in_empty;
  assign ext_out_valid = ~out_empty;
  assign out_pop       = ext_out_valid & ext_out_ready;

  io_sync_fifo #(.WIDTH(8), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push),
    .din   (ext_in_data),
    .pop   (in_ack),
    .dout  (i_port),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  io_sync_fifo #(.WIDTH(8), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (o_wr),
    .din   (o_port),
    .pop   (out_pop),
    .dout  (ext_out_data),
    .full  (out_full),
    .empty (out_empty),
    .count (unused_out_count)
  );

  always_ff @(posedge clk) begin
    if (rst)                               ovf <= 1'b0;
    else if (o_wr && out_full && !out_pop) ovf <= 1'b1;
  end

  // One pulse per batch: after the pulse the FSM parks in WAIT until the CPU
  // consumes a byte, then re-arms from IDLE if data is still buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pulse_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (int_en && (in_count != '0)) begin
            state     <= PULSE;
            pulse_cnt <= PULSE_LOAD;
          end
        end
        PULSE: begin
          if (pulse_cnt == '0) state <= WAIT;
          else                 pulse_cnt <= pulse_cnt - 1'b1;
        end
        WAIT: begin
          if (in_pop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign int_sig = (state == PULSE);

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed self-checking bench for io_bridge (depths 4, pulse 2).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_io_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_port;
  logic       in_ack;
  logic       int_sig;
  logic       int_en;
  logic [7:0] o_port;
  logic       o_wr;
  logic       ext_in_valid;
  logic       ext_in_ready;
  logic [7:0] ext_in_data;
  logic       ext_out_valid;
  logic       ext_out_ready;
  logic [7:0] ext_out_data;
  logic [2:0] in_count;
  logic       ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  io_bridge #(.IN_DEPTH(4), .OUT_DEPTH(4), .INT_PULSE(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_port        (i_port),
    .in_ack        (in_ack),
    .int_sig       (int_sig),
    .int_en        (int_en),
    .o_port        (o_port),
    .o_wr          (o_wr),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .ext_in_data   (ext_in_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .ext_out_data  (ext_out_data),
    .in_count      (in_count),
    .ovf           (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_ack = 1'b0; int_en = 1'b0; o_port = '0; o_wr = 1'b0;
    ext_in_valid = 1'b0; ext_in_data = '0; ext_out_ready = 1'b0;
    #1;
    do_reset();
    check("rst_in_count", 32'(in_count), 0);
    check("rst_int_sig", 32'(int_sig), 0);
    check("rst_i_port", 32'(i_port), 8'h00);
    check("rst_out_valid", 32'(ext_out_valid), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_in_ready", 32'(ext_in_ready), 1);

    // Single byte, interrupt pulse of two cycles, then WAIT until acked
    int_en = 1'b1;
    ext_in_valid = 1'b1; ext_in_data = 8'hA5;
    tick();
    ext_in_valid = 1'b0;
    check("t1_i_port", 32'(i_port), 8'hA5);
    check("t1_count", 32'(in_count), 1);
    check("t1_int_n0", 32'(int_sig), 0);
    tick(); check("t1_int_n1", 32'(int_sig), 1);
    tick(); check("t1_int_n2", 32'(int_sig), 1);
    tick(); check("t1_int_n3", 32'(int_sig), 0);
    tick(); check("t1_int_wait", 32'(int_sig), 0);
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    check("t1_ack_i_port", 32'(i_port), 8'h00);
    check("t1_ack_count", 32'(in_count), 0);
    tick(); check("t1_idle_int", 32'(int_sig), 0);
    int_en = 1'b0;

    // Fill input FIFO, hold a fifth byte, then drain in order
    for (int k = 1; k <= 4; k++) begin
      ext_in_valid = 1'b1; ext_in_data = 8'(k);
      tick();
    end
    check("t2_ready_full", 32'(ext_in_ready), 0);
    check("t2_count_full", 32'(in_count), 4);
    ext_in_data = 8'h05;
    tick(); tick();
    ext_in_valid = 1'b0;
    check("t2_no_5th", 32'(in_count), 4);
    check("t2_no_int", 32'(int_sig), 0);
    in_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("t2_drain", 32'(i_port), 32'(k));
      tick();
    end
    in_ack = 1'b0;
    check("t2_empty_count", 32'(in_count), 0);
    check("t2_empty_i_port", 32'(i_port), 8'h00);
    check("t2_ready_again", 32'(ext_in_ready), 1);

    // Five CPU writes into a stalled output FIFO: last one dropped
    ext_out_ready = 1'b0;
    o_wr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      o_port = 8'(8'h10 + k);
      tick();
      if (k == 3) begin
        check("t3_ovf_pre", 32'(ovf), 0);
        check("t3_valid", 32'(ext_out_valid), 1);
        check("t3_head", 32'(ext_out_data), 8'h10);
      end
    end
    o_wr = 1'b0;
    check("t3_ovf_set", 32'(ovf), 1);
    ext_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t3_deliver", 32'(ext_out_data), 32'(8'h10 + k));
      tick();
    end
    check("t3_drained", 32'(ext_out_valid), 0);
    check("t3_ovf_sticky", 32'(ovf), 1);
    ext_out_ready = 1'b0;

    // Full output FIFO: write with a simultaneous pop is accepted
    do_reset();
    check("t4_ovf_cleared", 32'(ovf), 0);
    o_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      o_port = 8'(8'h20 + k);
      tick();
    end
    o_port = 8'h24; ext_out_ready = 1'b1;
    check("t4_head_pre", 32'(ext_out_data), 8'h20);
    tick();
    o_wr = 1'b0;
    check("t4_ovf", 32'(ovf), 0);
    for (int k = 1; k <= 4; k++) begin
      check("t4_drain", 32'(ext_out_data), 32'(8'h20 + k));
      tick();
    end
    check("t4_drained", 32'(ext_out_valid), 0);
    check("t4_ovf_end", 32'(ovf), 0);
    ext_out_ready = 1'b0;

    // Reset during the pulse with three bytes buffered
    int_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ext_in_valid = 1'b1; ext_in_data = 8'(8'h31 + k);
      tick();
    end
    check("t5_int_pulse", 32'(int_sig), 1);
    check("t5_count3", 32'(in_count), 3);
    ext_in_data = 8'h44;
    rst = 1'b1;
    tick();
    rst = 1'b0; ext_in_valid = 1'b0;
    check("t5_int_cleared", 32'(int_sig), 0);
    check("t5_count0", 32'(in_count), 0);
    check("t5_i_port", 32'(i_port), 8'h00);
    check("t5_ready", 32'(ext_in_ready), 1);
    tick(); check("t5_no_refire", 32'(int_sig), 0);

    // Two bytes, one ack in WAIT re-fires; with int_en low nothing fires
    ext_in_valid = 1'b1; ext_in_data = 8'h51; tick();
    ext_in_data = 8'h52; tick();
    ext_in_valid = 1'b0;
    check("t6_p1_a", 32'(int_sig), 1);
    tick(); check("t6_p1_b", 32'(int_sig), 1);
    tick(); check("t6_p1_end", 32'(int_sig), 0);
    tick(); check("t6_wait", 32'(int_sig), 0);
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    check("t6_ack_int", 32'(int_sig), 0);
    check("t6_ack_count", 32'(in_count), 1);
    check("t6_ack_i_port", 32'(i_port), 8'h52);
    tick(); check("t6_p2_a", 32'(int_sig), 1);
    tick(); check("t6_p2_b", 32'(int_sig), 1);
    tick(); check("t6_p2_end", 32'(int_sig), 0);
    int_en = 1'b0;
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    ext_in_valid = 1'b1; ext_in_data = 8'h60; tick();
    ext_in_valid = 1'b0;
    check("t6_dis_count", 32'(in_count), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_dis_int", 32'(int_sig), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
